// File: rtl/muldiv_pkg.sv
// Shared encodings and defaults for the multi-cycle multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_e;

  function automatic logic op_is_div(input op_e op);
    return (op == OP_DIVU) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_signed(input op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide on a 2*WIDTH accumulator.
// Multiply: acc = {partial product, remaining multiplier}. Divide: acc = {remainder, dividend/quotient}.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] nxt_c
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  always_comb begin
    nxt_c  = acc;
    sum    = '0;
    rem_sh = '0;
    diff   = '0;
    if (!is_div) begin
      sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand & {WIDTH{acc[0]}}};
      nxt_c = {sum, acc[WIDTH-1:1]};
    end else begin
      // Borrow out of the trial subtract means the divisor did not fit: restore.
      rem_sh = acc[2*WIDTH-1:WIDTH-1];
      diff   = rem_sh - {1'b0, operand};
      if (!diff[WIDTH]) begin
        nxt_c = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        nxt_c = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers.
// One bit per RUN cycle; sign correction and the HI/LO write happen in FIX.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] oprd1,
  input  logic [WIDTH-1:0] oprd2,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e             state;
  state_e             state_nxt;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_step_c;
  logic [WIDTH-1:0]   opnd;
  logic               is_div_q;
  logic               s1_q;
  logic               s2_q;
  logic               dz_q;

  logic               accept_c;
  logic               div_in_c;
  logic               neg1_c;
  logic               neg2_c;
  logic               dz_in_c;
  logic [WIDTH-1:0]   mag1_c;
  logic [WIDTH-1:0]   mag2_c;
  logic [2*WIDTH-1:0] prod_c;
  logic [WIDTH-1:0]   fix_hi_c;
  logic [WIDTH-1:0]   fix_lo_c;

  // Operand decode at accept; magnitudes only for the signed ops.
  always_comb begin
    div_in_c = op_is_div(op_e'(op));
    neg1_c   = op_is_signed(op_e'(op)) && oprd1[WIDTH-1];
    neg2_c   = op_is_signed(op_e'(op)) && oprd2[WIDTH-1];
    dz_in_c  = div_in_c && (oprd2 == '0);
    mag1_c   = neg1_c ? -oprd1 : oprd1;
    mag2_c   = neg2_c ? -oprd2 : oprd2;
    accept_c = start && ((state == S_IDLE) || (state == S_DONE));
  end

  muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .acc    (acc),
    .operand(opnd),
    .is_div (is_div_q),
    .nxt_c  (acc_step_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = dz_in_c ? S_FIX : S_RUN;
      S_RUN:   if (cnt == CNT_LAST) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_DONE;
      S_DONE:  state_nxt = start ? (dz_in_c ? S_FIX : S_RUN) : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state == S_RUN) || (state == S_FIX);
    done        = (state == S_DONE);
    div_by_zero = (state == S_DONE) && dz_q;
  end

  // Result formatting for the FIX write; sign flags are already gated by the signed ops.
  always_comb begin
    prod_c   = acc;
    fix_hi_c = acc[2*WIDTH-1:WIDTH];
    fix_lo_c = acc[WIDTH-1:0];
    if (dz_q) begin
      fix_hi_c = acc[WIDTH-1:0];
      fix_lo_c = '1;
    end else if (is_div_q) begin
      if (s1_q ^ s2_q) fix_lo_c = -acc[WIDTH-1:0];
      if (s1_q)        fix_hi_c = -acc[2*WIDTH-1:WIDTH];
    end else if (s1_q ^ s2_q) begin
      prod_c   = -acc;
      fix_hi_c = prod_c[2*WIDTH-1:WIDTH];
      fix_lo_c = prod_c[WIDTH-1:0];
    end
  end

  // Datapath: operand capture, iteration, and the HI/LO write.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      is_div_q <= 1'b0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      dz_q     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      if (accept_c) begin
        cnt      <= '0;
        is_div_q <= div_in_c;
        s1_q     <= neg1_c;
        s2_q     <= neg2_c;
        dz_q     <= dz_in_c;
        opnd     <= div_in_c ? mag2_c : mag1_c;
        // Divide by zero keeps the raw dividend so HI returns it unmodified.
        if (dz_in_c) begin
          acc <= {{WIDTH{1'b0}}, oprd1};
        end else begin
          acc <= {{WIDTH{1'b0}}, (div_in_c ? mag1_c : mag2_c)};
        end
      end else if (state == S_RUN) begin
        acc <= acc_step_c;
        cnt <= cnt + CW'(1);
      end
      if (state == S_FIX) begin
        hi <= fix_hi_c;
        lo <= fix_lo_c;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected HI/LO/flag and done cycle queued at issue.
module tb_muldiv_unit;

  localparam int unsigned W = 32;
  localparam logic [1:0] MULTU = 2'b00;
  localparam logic [1:0] MULT  = 2'b01;
  localparam logic [1:0] DIVU  = 2'b10;
  localparam logic [1:0] DIV   = 2'b11;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] oprd1;
  logic [W-1:0] oprd2;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op         (op),
    .oprd1      (oprd1),
    .oprd2      (oprd2),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero),
    .hi         (hi),
    .lo         (lo)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t got_e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic done_d = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t        r;
    logic [63:0] p;
    longint      sa;
    longint      sbv;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    case (o)
      2'b00:   p = {32'h0, a} * {32'h0, b};
      2'b01:   p = 64'(sa * sbv);
      2'b10:   p = (b == 0) ? {a, 32'hffffffff} : {a % b, a / b};
      default: p = (b == 0) ? {a, 32'hffffffff} : {32'(sa % sbv), 32'(sa / sbv)};
    endcase
    r.hi  = p[63:32];
    r.lo  = p[31:0];
    r.dz  = o[1] && (b == 0);
    r.due = 0;
    return r;
  endfunction

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (div_by_zero) chk("dz_with_done", done, 1);
    if (done) begin
      chk("done_single", done_d, 0);
      if (sb.size() == 0) begin
        chk("spurious_done", done, 0);
      end else begin
        got_e = sb.pop_front();
        chk("hi", hi, got_e.hi);
        chk("lo", lo, got_e.lo);
        chk("dz", div_by_zero, got_e.dz);
        chk("latency", cyc, got_e.due);
        chk("busy_at_done", busy, 0);
      end
    end else if (sb.size() > 0 && cyc >= sb[0].due) begin
      chk("done_missing", done, 1);
      void'(sb.pop_front());
    end
    done_d = done;
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
    exp_t e;
    @(posedge clk);
    #1;
    op    = o;
    oprd1 = a;
    oprd2 = b;
    start = 1'b1;
    e.hi  = ehi;
    e.lo  = elo;
    e.dz  = edz;
    e.due = cyc + (edz ? 2 : 34);
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_accept", busy, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) chk("drain", sb.size(), 0);
    repeat (2) @(posedge clk);
  endtask

  task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
    issue(o, a, b, ehi, elo, edz);
    drain();
  endtask

  task automatic run_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t r;
    r = model(o, a, b);
    run(o, a, b, r.hi, r.lo, r.dz);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cyc %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst   = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    oprd1 = '0;
    oprd2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dz", div_by_zero, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    rst = 1'b0;

    run(MULTU, 32'hffffffff, 32'hffffffff, 32'hfffffffe, 32'h00000001, 1'b0);
    run(MULT,  32'hfffffffd, 32'd7,        32'hffffffff, 32'hffffffeb, 1'b0);
    run(MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);
    run(DIV,   32'hfffffff9, 32'd2,        32'hffffffff, 32'hfffffffd, 1'b0);
    run(DIVU,  32'd7,        32'd2,        32'd1,        32'd3,        1'b0);
    run(DIV,   32'h80000000, 32'hffffffff, 32'h00000000, 32'h80000000, 1'b0);

    // Stray start with new operands during RUN must not disturb the op.
    issue(MULTU, 32'h1234, 32'h10, 32'h0, 32'h12340, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    op    = DIVU;
    oprd1 = 32'd100;
    oprd2 = 32'd0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    drain();

    run(DIVU, 32'd5, 32'd0, 32'd5, 32'hffffffff, 1'b1);
    oprd1 = 32'd99;
    oprd2 = 32'd3;
    repeat (5) @(posedge clk);
    #1;
    chk("hold_hi", hi, 32'd5);
    chk("hold_lo", lo, 32'hffffffff);

    // Reset in the 10th RUN cycle aborts without done.
    @(posedge clk);
    #1;
    op    = MULTU;
    oprd1 = 32'h1111;
    oprd2 = 32'h2222;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    repeat (40) @(posedge clk);
    run(MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);

    // Back-to-back issue in the DONE cycle.
    issue(MULT, 32'hfffffffd, 32'd7, 32'hffffffff, 32'hffffffeb, 1'b0);
    n = 0;
    while (!done && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("b2b_first_done", done, 1);
    begin
      exp_t e;
      op    = DIVU;
      oprd1 = 32'd7;
      oprd2 = 32'd2;
      start = 1'b1;
      e.hi  = 32'd1;
      e.lo  = 32'd3;
      e.dz  = 1'b0;
      e.due = cyc + 34;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b_done_fall", done, 0);
    chk("b2b_busy_rise", busy, 1);
    drain();

    for (int i = 0; i < 8; i++) begin
      logic [1:0]  o;
      logic [31:0] a;
      logic [31:0] b;
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      if (i == 3)     b = 32'd0;
      else if (o[1])  b = (i[0]) ? 32'($urandom_range(1, 1000)) : $urandom;
      else            b = $urandom;
      if (i == 3) o = DIV;
      run_model(o, a, b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle sequencer for integer multiply and divide in the MIPS processor, owning the HI/LO result registers. Replaces single-cycle `*` and `/` with a one-bit-per-cycle shift-add multiplier and restoring divider. Sits beside the ALU in the execute stage. The pipeline stalls on `busy` and reads HI/LO for MFHI/MFLO.

## Interface
- `WIDTH`, default 32: operand width; HI and LO are each `WIDTH` bits.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request; sampled only while `busy`=0.
- `op` in 2: operation; 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `oprd1` in WIDTH: multiplicand or dividend; captured at accept.
- `oprd2` in WIDTH: multiplier or divisor; captured at accept.
- `busy` out 1: operation in flight; new starts ignored.
- `done` out 1: one-cycle pulse; HI/LO hold the new result in this cycle.
- `div_by_zero` out 1: high together with `done` for a DIV or DIVU with `oprd2`=0.
- `hi` out WIDTH: MULT high word, or DIV remainder.
- `lo` out WIDTH: MULT low word, or DIV quotient.

## Operation
- States:
  - IDLE: accept start.
  - RUN: iterate.
  - FIX: sign correction and HI/LO write.
  - DONE: pulse `done`.
- Transitions:
  - IDLE→RUN on `start`.
  - RUN→FIX when the iteration counter reaches `WIDTH`-1.
  - FIX→DONE.
  - DONE→IDLE, or DONE→RUN if `start`=1 in DONE (back-to-back issue allowed).
- Accept: latch `op`, `|oprd1|`, `|oprd2|` and the sign flags; counter=0.
  - Magnitudes are taken only for MULT/DIV; MULTU/DIVU use raw values.
- Multiply: 2·WIDTH-bit accumulator, shift-add on the LSB of the multiplier, one bit per RUN cycle.
  - FIX negates the 2·WIDTH result if sign1^sign2 (signed op only).
- Divide: restoring divide, WIDTH-bit partial remainder, one quotient bit per RUN cycle.
  - FIX: quotient negated if sign1^sign2; remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF yields LO=0x80000000, HI=0, with no trap and no flag.
- Divide by zero (divisor=0 at accept, DIV or DIVU): RUN is skipped; IDLE→FIX directly.
  - Result: HI=`oprd1` as given, LO=all ones, `div_by_zero`=1 in the DONE cycle.
- HI/LO are written only in FIX and hold their value at all other times.
- `start` while `busy`=1 is ignored, with no queuing. Operands are not sampled outside accept.

## Timing
- Reset values:
  - `busy`=0, `done`=0, `div_by_zero`=0.
  - `hi`=0, `lo`=0.
  - State IDLE, counter 0.
- `rst` mid-operation: abort at the next edge; all outputs and HI/LO return to reset values; no `done` issued.
- Normal op with start accepted at edge k:
  - `busy`=1 in the cycles after edges k … k+32.
  - RUN occupies edges k+1 … k+32; FIX occurs at edge k+33.
  - `done`=1 and `busy`=0 in the single cycle after edge k+33; HI/LO are valid from that cycle.
  - Total latency is 33 cycles for WIDTH=32.
- Divide by zero:
  - FIX at edge k+1.
  - `done` and `div_by_zero` high in the cycle after edge k+1.
- A start sampled in the DONE cycle begins a new op. `done` then falls and `busy` rises next cycle.
- `done` and `div_by_zero` are never high for more than one consecutive cycle per operation.

## Structure
- Package `muldiv_pkg`:
  - `op` encodings `OP_MULTU`, `OP_MULT`, `OP_DIVU`, `OP_DIV`.
  - State enum (IDLE, RUN, FIX, DONE).
  - Default `WIDTH`.
- One combinational sub-module, `muldiv_step`: given accumulator/remainder, operand and mode, it returns the next-iteration value (shift-add or trial-subtract-restore).
- `muldiv_unit` keeps the FSM, counter, sign flags and HI/LO registers.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF, start at edge k -> HI=0xFFFFFFFE, LO=0x00000001; `done` exactly one cycle, after edge k+33.
- MULT −3 × 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- MULT 0x80000000 × 0x80000000 -> HI=0x40000000, LO=0.
- DIV −7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 7 / 2 -> LO=3, HI=1.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0, `div_by_zero`=0.
- DIVU 5 / 0 -> `done` and `div_by_zero` in the cycle after edge k+1; HI=5, LO=0xFFFFFFFF; HI/LO unchanged until the next FIX.
- Protocol checks:
  - `start` pulsed with new operands during RUN -> ignored; the result matches the first op.
  - `rst` at the 10th RUN cycle -> `busy`=0 and HI=LO=0 the next cycle, no `done`; a following MULTU 6×7 gives LO=42, HI=0.
  - Back-to-back start in the DONE cycle -> second result correct, second `done` 34 cycles after the first.
